// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared types and funct3 encodings for the LSU memory controller.
// Holds the FSM state type and the load/store funct3 legality check.
package lsu_mem_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRd,
    StWr,
    StResp
  } lsu_state_e;

  localparam logic [2:0] F3B  = 3'b000;
  localparam logic [2:0] F3H  = 3'b001;
  localparam logic [2:0] F3W  = 3'b010;
  localparam logic [2:0] F3Bu = 3'b100;
  localparam logic [2:0] F3Hu = 3'b101;

  // Stores only have signed encodings; loads add the unsigned byte/half forms.
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    logic ok;
    ok = (f3 == F3B) || (f3 == F3H) || (f3 == F3W);
    if (!we) begin
      ok = ok || (f3 == F3Bu) || (f3 == F3Hu);
    end
    return ok;
  endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// Core-side and memory-side signal bundle of the LSU memory controller.
// master = the LSU itself, slave = the core/memory environment around it.
interface lsu_mem_ctrl_if #(
  parameter int unsigned AW = 32
) ();

  logic          core_req;
  logic          core_ready;
  logic          core_we;
  logic [2:0]    core_funct3;
  logic [AW-1:0] core_addr;
  logic [31:0]   core_wdata;
  logic          core_done;
  logic [31:0]   core_rdata;
  logic          core_err;

  logic          mem_valid;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic          mem_ready;

  modport master (
    input  core_req, core_we, core_funct3, core_addr, core_wdata, mem_rdata, mem_ready,
    output core_ready, core_done, core_rdata, core_err, mem_valid, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output core_req, core_we, core_funct3, core_addr, core_wdata, mem_rdata, mem_ready,
    input  core_ready, core_done, core_rdata, core_err, mem_valid, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/lsu_mem_ctrl_store_handler.sv
// Store merge datapath: inserts the byte/halfword store data into the word read from memory.
// Full-word stores pass the store data straight through.
module lsu_mem_ctrl_store_handler
  import lsu_mem_ctrl_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] word_o
);

  always_comb begin
    word_o = rdata_i;
    case (funct3_i)
      F3B: word_o[{off_i, 3'b000} +: 8] = wdata_i[7:0];
      F3H: begin
        if (off_i[1]) begin
          word_o[31:16] = wdata_i[15:0];
        end else begin
          word_o[15:0] = wdata_i[15:0];
        end
      end
      default: word_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// LSU load/store sequencer: sole master of a word-only, variable-latency data memory port.
// Optional LSU_MISALIGN_TRAP_EN: misaligned halfword/word accesses complete with an error.
module lsu_mem_ctrl
  import lsu_mem_ctrl_pkg::*;
#(
  parameter int unsigned AW      = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input logic            clk,
  input logic            resetn,
  lsu_mem_ctrl_if.master lsu_io
);

  localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  lsu_state_e    state_q, state_d;
  logic          we_q, we_d;
  logic [2:0]    f3_q, f3_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic        misalign;
  logic        timeout_hit;
  logic        cnt_sat;
  logic [31:0] merged;
  logic [31:0] load_data;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

`ifdef LSU_MISALIGN_TRAP_EN
  always_comb begin
    misalign = 1'b0;
    case (lsu_io.core_funct3)
      F3H, F3Hu: misalign = lsu_io.core_addr[0];
      F3W:       misalign = |lsu_io.core_addr[1:0];
      default:   misalign = 1'b0;
    endcase
  end
`else
  assign misalign = 1'b0;
`endif

  // TIMEOUT == 0 disables the watchdog; the counter then stays at zero.
  if (TIMEOUT == 0) begin : g_no_timeout
    assign timeout_hit = 1'b0;
    assign cnt_sat     = 1'b1;
  end else begin : g_timeout
    assign timeout_hit = (cnt_q == CntW'(TIMEOUT - 1));
    assign cnt_sat     = (cnt_q == CntW'(TIMEOUT));
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (lsu_io.core_req) begin
          we_d    = lsu_io.core_we;
          f3_d    = lsu_io.core_funct3;
          addr_d  = lsu_io.core_addr;
          wdata_d = lsu_io.core_wdata;
          err_d   = 1'b0;
          cnt_d   = '0;
          if (!f3_legal(lsu_io.core_we, lsu_io.core_funct3) || misalign) begin
            err_d   = 1'b1;
            state_d = StResp;
          end else if (lsu_io.core_we && (lsu_io.core_funct3 == F3W)) begin
            state_d = StWr;
          end else begin
            state_d = StRd;
          end
        end
      end
      StRd, StWr: begin
        // A ready in the final allowed cycle takes priority over the timeout.
        if (lsu_io.mem_ready) begin
          cnt_d = '0;
          if (state_q == StRd) begin
            rdata_d = lsu_io.mem_rdata;
            state_d = we_q ? StWr : StResp;
          end else begin
            state_d = StResp;
          end
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = StResp;
        end else if (!cnt_sat) begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  lsu_mem_ctrl_store_handler u_store_handler (
    .rdata_i  (rdata_q),
    .wdata_i  (wdata_q),
    .off_i    (addr_q[1:0]),
    .funct3_i (f3_q),
    .word_o   (merged)
  );

  always_comb begin
    byte_sel = 8'(rdata_q >> {addr_q[1:0], 3'b000});
    half_sel = addr_q[1] ? rdata_q[31:16] : rdata_q[15:0];
    case (f3_q)
      F3B:     load_data = {{24{byte_sel[7]}}, byte_sel};
      F3H:     load_data = {{16{half_sel[15]}}, half_sel};
      F3Bu:    load_data = {24'h0, byte_sel};
      F3Hu:    load_data = {16'h0, half_sel};
      default: load_data = rdata_q;
    endcase
  end

  // Outputs are pure state decodes so reset clears them without waiting for a clock.
  always_comb begin
    lsu_io.core_ready = (state_q == StIdle);
    lsu_io.core_done  = (state_q == StResp);
    lsu_io.core_err   = (state_q == StResp) && err_q;
    lsu_io.core_rdata = ((state_q == StResp) && !err_q && !we_q) ? load_data : 32'h0;
    lsu_io.mem_valid  = (state_q == StRd) || (state_q == StWr);
    lsu_io.mem_we     = (state_q == StWr);
    lsu_io.mem_addr   = lsu_io.mem_valid ? {addr_q[AW-1:2], 2'b00} : '0;
    lsu_io.mem_wdata  = (state_q == StWr) ? merged : 32'h0;
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: scoreboarded memory model plus per-scenario tasks.
// Expects the default build (LSU_MISALIGN_TRAP_EN undefined).
module tb_lsu_mem_ctrl;

  localparam int unsigned AW      = 32;
  localparam int unsigned TIMEOUT = 16;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } mem_txn_t;

  typedef struct {
    int          lat;
    logic        err;
    logic [31:0] rdata;
  } resp_t;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  lsu_mem_ctrl_if #(.AW(AW)) bus ();

  lsu_mem_ctrl #(
    .AW      (AW),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .lsu_io (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  mem_txn_t exp_mem[$];
  resp_t    exp_resp[$];

  // Memory model state; only the model process writes these.
  logic [31:0] mem[logic [31:0]];
  int          wcnt         = 0;
  int          valid_cycles = 0;

  // Knobs driven by the test process.
  int          wait_states = 0;
  bit          stall       = 1'b0;
  bit          pl_req      = 1'b0;
  logic [31:0] pl_addr     = 32'h0;
  logic [31:0] pl_data     = 32'h0;

  always @(negedge clk) begin
    mem_txn_t    e;
    logic [31:0] rd;
    if (pl_req) mem[pl_addr] = pl_data;
    if (bus.mem_ready === 1'b1) begin
      bus.mem_ready = 1'b0;
      wcnt          = 0;
    end else if (bus.mem_ready !== 1'b0) begin
      bus.mem_ready = 1'b0;
      bus.mem_rdata = 32'h0;
    end
    if (bus.mem_valid !== 1'b1) begin
      wcnt = 0;
    end else begin
      valid_cycles++;
      if (!stall && wcnt >= wait_states) begin
        rd            = mem.exists(bus.mem_addr) ? mem[bus.mem_addr] : 32'h0;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = rd;
        if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
        n_tests++;
        if (exp_mem.size() == 0) begin
          n_fail++;
          $display("FAIL mem_txn: unexpected access we=%0b addr=%h wdata=%h", bus.mem_we,
                   bus.mem_addr, bus.mem_wdata);
        end else begin
          e = exp_mem.pop_front();
          if (bus.mem_we !== e.we || bus.mem_addr !== e.addr ||
              (e.we && bus.mem_wdata !== e.data)) begin
            n_fail++;
            $display("FAIL mem_txn: got we=%0b addr=%h wdata=%h, required we=%0b addr=%h wdata=%h",
                     bus.mem_we, bus.mem_addr, bus.mem_wdata, e.we, e.addr, e.data);
          end
        end
      end else begin
        wcnt++;
      end
    end
  end

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    pl_addr = a;
    pl_data = d;
    pl_req  = 1'b1;
    @(negedge clk);
    #1 pl_req = 1'b0;
  endtask

  // Issues one request, scrambles the inputs after acceptance, waits (bounded) for core_done.
  task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output int lat, output logic done,
                         output logic err, output logic [31:0] rdata);
    int t;
    @(negedge clk);
    t = 0;
    while (bus.core_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    bus.core_req    = 1'b1;
    bus.core_we     = we;
    bus.core_funct3 = f3;
    bus.core_addr   = a;
    bus.core_wdata  = wd;
    @(posedge clk);
    #1;
    bus.core_req    = 1'b0;
    bus.core_we     = ~we;
    bus.core_funct3 = 3'($urandom);
    bus.core_addr   = $urandom;
    bus.core_wdata  = $urandom;
    lat  = 0;
    done = 1'b0;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
      done = (bus.core_done === 1'b1);
    end
    err   = bus.core_err;
    rdata = bus.core_rdata;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({bus.core_ready, bus.core_done, bus.core_err, bus.core_rdata, bus.mem_valid, bus.mem_we,
         bus.mem_addr, bus.mem_wdata} !== {1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0}) begin
      n_fail++;
      $display("FAIL reset_outputs: ready=%b done=%b err=%b rdata=%h mv=%b mwe=%b ma=%h mwd=%h, required ready=1 rest 0",
               bus.core_ready, bus.core_done, bus.core_err, bus.core_rdata, bus.mem_valid,
               bus.mem_we, bus.mem_addr, bus.mem_wdata);
    end
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_store_word();
    int lat; logic done, err; logic [31:0] rdata; resp_t e;
    logic [31:0] tbl_wd[2]  = '{32'hAABBCCDD, 32'h01234567};
    int          tbl_ws[2]  = '{0, 1};
    for (int i = 0; i < 2; i++) begin
      wait_states = tbl_ws[i];
      exp_mem.push_back('{we: 1'b1, addr: 32'h104, data: tbl_wd[i]});
      exp_resp.push_back('{lat: 2 + tbl_ws[i], err: 1'b0, rdata: 32'h0});
      run_req(1'b1, 3'b010, 32'h104, tbl_wd[i], lat, done, err, rdata);
      e = exp_resp.pop_front();
      n_tests++;
      if (!done || lat !== e.lat || err !== e.err || rdata !== e.rdata) begin
        n_fail++;
        $display("FAIL sw_%0d: done=%b lat=%0d err=%b rdata=%h, required lat=%0d err=%b rdata=%h",
                 i, done, lat, err, rdata, e.lat, e.err, e.rdata);
      end
    end
    wait_states = 0;
  endtask

  task automatic test_sub_word_store();
    int lat; logic done, err; logic [31:0] rdata; resp_t e;
    logic [2:0]  tf3[3] = '{3'b000, 3'b001, 3'b000};
    logic [31:0] tad[3] = '{32'h102, 32'h102, 32'h100};
    logic [31:0] twd[3] = '{32'hFFFFFFAA, 32'h0000BEEF, 32'h12345677};
    logic [31:0] told[3] = '{32'h11223344, 32'h11AA3344, 32'hBEEF3344};
    logic [31:0] tnew[3] = '{32'h11AA3344, 32'hBEEF3344, 32'hBEEF3377};
    int          tws[3] = '{2, 0, 1};
    preload(32'h100, 32'h11223344);
    for (int i = 0; i < 3; i++) begin
      wait_states = tws[i];
      exp_mem.push_back('{we: 1'b0, addr: 32'h100, data: told[i]});
      exp_mem.push_back('{we: 1'b1, addr: 32'h100, data: tnew[i]});
      exp_resp.push_back('{lat: 3 + 2 * tws[i], err: 1'b0, rdata: 32'h0});
      run_req(1'b1, tf3[i], tad[i], twd[i], lat, done, err, rdata);
      e = exp_resp.pop_front();
      n_tests++;
      if (!done || lat !== e.lat || err !== e.err || rdata !== e.rdata) begin
        n_fail++;
        $display("FAIL subword_store_%0d: done=%b lat=%0d err=%b rdata=%h, required lat=%0d err=%b rdata=%h",
                 i, done, lat, err, rdata, e.lat, e.err, e.rdata);
      end
    end
    wait_states = 0;
  endtask

  task automatic test_loads();
    int lat; logic done, err; logic [31:0] rdata; resp_t e;
    logic [2:0]  tf3[7] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b000, 3'b001};
    logic [31:0] tad[7] = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h100, 32'h101, 32'h100};
    logic [31:0] trd[7] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8022, 32'h00008022,
                            32'h80223344, 32'h00000033, 32'h00003344};
    preload(32'h100, 32'h80223344);
    for (int i = 0; i < 7; i++) begin
      wait_states = i % 2;
      exp_mem.push_back('{we: 1'b0, addr: 32'h100, data: 32'h0});
      exp_resp.push_back('{lat: 2 + (i % 2), err: 1'b0, rdata: trd[i]});
      run_req(1'b0, tf3[i], tad[i], 32'hDEADBEEF, lat, done, err, rdata);
      e = exp_resp.pop_front();
      n_tests++;
      if (!done || lat !== e.lat || err !== e.err || rdata !== e.rdata) begin
        n_fail++;
        $display("FAIL load_%0d: done=%b lat=%0d err=%b rdata=%h, required lat=%0d err=%b rdata=%h",
                 i, done, lat, err, rdata, e.lat, e.err, e.rdata);
      end
    end
    wait_states = 0;
  endtask

  task automatic test_errors();
    int lat; logic done, err; logic [31:0] rdata; resp_t e; int vc0;
    logic       twe[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [2:0] tf3[4] = '{3'b100, 3'b011, 3'b011, 3'b110};
    for (int i = 0; i < 4; i++) begin
      vc0 = valid_cycles;
      exp_resp.push_back('{lat: 1, err: 1'b1, rdata: 32'h0});
      run_req(twe[i], tf3[i], 32'h100, 32'h0, lat, done, err, rdata);
      e = exp_resp.pop_front();
      n_tests++;
      if (!done || lat !== e.lat || err !== e.err || rdata !== e.rdata ||
          valid_cycles != vc0) begin
        n_fail++;
        $display("FAIL illegal_f3_%0d: done=%b lat=%0d err=%b rdata=%h mem_cycles=%0d, required lat=1 err=1 rdata=0 mem_cycles=0",
                 i, done, lat, err, rdata, valid_cycles - vc0);
      end
    end
    // Misaligned SH in the default build: offset bit 0 ignored, lands in halfword 0.
    exp_mem.push_back('{we: 1'b0, addr: 32'h100, data: 32'h0});
    exp_mem.push_back('{we: 1'b1, addr: 32'h100, data: 32'h80225566});
    exp_resp.push_back('{lat: 3, err: 1'b0, rdata: 32'h0});
    run_req(1'b1, 3'b001, 32'h101, 32'h00005566, lat, done, err, rdata);
    e = exp_resp.pop_front();
    n_tests++;
    if (!done || lat !== e.lat || err !== e.err || rdata !== e.rdata) begin
      n_fail++;
      $display("FAIL misaligned_sh: done=%b lat=%0d err=%b rdata=%h, required lat=%0d err=%b rdata=%h",
               done, lat, err, rdata, e.lat, e.err, e.rdata);
    end
  endtask

  task automatic test_timeout();
    int lat; logic done, err; logic [31:0] rdata; resp_t e; int vc0;
    stall = 1'b1;
    vc0   = valid_cycles;
    exp_resp.push_back('{lat: TIMEOUT + 1, err: 1'b1, rdata: 32'h0});
    run_req(1'b0, 3'b010, 32'h200, 32'h0, lat, done, err, rdata);
    e = exp_resp.pop_front();
    n_tests++;
    if (!done || lat !== e.lat || err !== e.err || rdata !== e.rdata ||
        valid_cycles - vc0 != TIMEOUT || bus.mem_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout: done=%b lat=%0d err=%b rdata=%h valid_cycles=%0d mv=%b, required lat=%0d err=1 rdata=0 valid_cycles=%0d mv=0",
               done, lat, err, rdata, valid_cycles - vc0, bus.mem_valid, e.lat, TIMEOUT);
    end
    stall = 1'b0;
    preload(32'h200, 32'hCAFEF00D);
    wait_states = TIMEOUT - 1;
    exp_mem.push_back('{we: 1'b0, addr: 32'h200, data: 32'h0});
    exp_resp.push_back('{lat: TIMEOUT + 1, err: 1'b0, rdata: 32'hCAFEF00D});
    run_req(1'b0, 3'b010, 32'h200, 32'h0, lat, done, err, rdata);
    e = exp_resp.pop_front();
    n_tests++;
    if (!done || lat !== e.lat || err !== e.err || rdata !== e.rdata) begin
      n_fail++;
      $display("FAIL ready_at_limit: done=%b lat=%0d err=%b rdata=%h, required lat=%0d err=%b rdata=%h",
               done, lat, err, rdata, e.lat, e.err, e.rdata);
    end
    wait_states = 0;
  endtask

  task automatic test_reset_mid_access();
    int lat; logic done, err; logic [31:0] rdata; resp_t e; int seen;
    stall = 1'b1;
    @(negedge clk);
    bus.core_req    = 1'b1;
    bus.core_we     = 1'b1;
    bus.core_funct3 = 3'b010;
    bus.core_addr   = 32'h300;
    bus.core_wdata  = 32'h55AA55AA;
    @(posedge clk);
    #1 bus.core_req = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (bus.mem_valid !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 32'h300) begin
      n_fail++;
      $display("FAIL wr_wait: mv=%b mwe=%b ma=%h, required mv=1 mwe=1 ma=00000300",
               bus.mem_valid, bus.mem_we, bus.mem_addr);
    end
    #2 resetn = 1'b0;
    #1;
    n_tests++;
    if (bus.mem_valid !== 1'b0 || bus.core_ready !== 1'b1 || bus.core_done !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: mv=%b ready=%b done=%b, required mv=0 ready=1 done=0",
               bus.mem_valid, bus.core_ready, bus.core_done);
    end
    @(negedge clk);
    resetn = 1'b1;
    stall  = 1'b0;
    seen   = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.core_done === 1'b1 || bus.mem_valid === 1'b1) seen++;
    end
    n_tests++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL post_reset_idle: done/mem_valid seen %0d cycles, required 0", seen);
    end
    exp_mem.push_back('{we: 1'b1, addr: 32'h304, data: 32'h0BADF00D});
    exp_resp.push_back('{lat: 2, err: 1'b0, rdata: 32'h0});
    run_req(1'b1, 3'b010, 32'h306, 32'h0BADF00D, lat, done, err, rdata);
    e = exp_resp.pop_front();
    n_tests++;
    if (!done || lat !== e.lat || err !== e.err || rdata !== e.rdata) begin
      n_fail++;
      $display("FAIL sw_after_reset: done=%b lat=%0d err=%b rdata=%h, required lat=%0d err=%b rdata=%h",
               done, lat, err, rdata, e.lat, e.err, e.rdata);
    end
  endtask

  initial begin
    bus.core_req    = 1'b0;
    bus.core_we     = 1'b0;
    bus.core_funct3 = 3'b000;
    bus.core_addr   = 32'h0;
    bus.core_wdata  = 32'h0;
    test_reset();
    test_store_word();
    test_sub_word_store();
    test_loads();
    test_errors();
    test_timeout();
    test_reset_mid_access();
    repeat (2) @(negedge clk);
    n_tests++;
    if (exp_mem.size() != 0) begin
      n_fail++;
      $display("FAIL mem_drain: %0d expected accesses never seen, required 0", exp_mem.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
